// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared funct3 codes, FSM states and funct3 legality helpers
package dmem_responder_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - byte-lane enables, store merge, load extension, misalign detect
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;
  logic [31:0] wdata_rep;

  // Decode access size from funct3[1:0]; funct3[2] selects zero-extension for loads
  always_comb begin
    be_o       = 4'b0000;
    rdata_o    = 32'd0;
    misalign_o = 1'b0;
    wdata_rep  = wdata_i;
    shifted    = word_i >> {addr_lo_i, 3'b000};
    case (funct3_i[1:0])
      2'b00: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_rep = {4{wdata_i[7:0]}};
        rdata_o   = funct3_i[2] ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata_i[15:0]}};
        rdata_o    = funct3_i[2] ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        rdata_o    = word_i;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
    wword_o = word_i;
    for (int b = 0; b < 4; b++) begin
      if (be_o[b]) wword_o[8*b +: 8] = wdata_rep[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with req/rsp handshakes
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [0:DEPTH-1];

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word;
  logic [3:0]        lane_be;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;
  logic              misalign;
  logic              out_of_range;
  logic              f3_bad;
  logic              acc_err;
  logic              accept;
  logic              exec_now;

  assign word_idx     = addr_q[ADDR_W+1:2];
  assign cur_word     = mem_q[word_idx];
  assign out_of_range = |addr_q[31:ADDR_W+2];
  assign f3_bad       = we_q ? !store_f3_legal(funct3_q) : !load_f3_legal(funct3_q);
  assign acc_err      = f3_bad | misalign | out_of_range;
  assign accept       = req_valid && (state_q == IDLE);
  assign exec_now     = (state_q == WAIT) && (cnt_q == 4'd0);

  dmem_lane_align u_lane (
    .funct3_i   (funct3_q),
    .addr_lo_i  (addr_q[1:0]),
    .word_i     (cur_word),
    .wdata_i    (wdata_q),
    .be_o       (lane_be),
    .wword_o    (merged_word),
    .rdata_o    (load_data),
    .misalign_o (misalign)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, count down in WAIT, hold RESP until consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Request capture, latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        cnt_q    <= 4'(LATENCY - 1);
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (exec_now) begin
        rdata_q <= (!we_q && !acc_err) ? load_data : 32'd0;
        err_q   <= acc_err;
      end
    end
  end

  // Store commit on the WAIT->RESP edge; memory is never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && exec_now && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem_q[word_idx][8*b +: 8] <= merged_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench with behavioural memory model for dmem_responder
module tb_dmem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int WORDS   = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Behavioural memory: byte-granular view of the word array
  logic [31:0] mm [0:WORDS-1];

  function automatic void model_exec(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, output logic [31:0] rd, output bit err);
    int size, off, idx;
    bit legal;
    logic [31:0] mask, val;
    off = int'(addr % 4);
    idx = int'((addr / 4) % WORDS);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (size != 0) && !(we && f3 >= 3'd4);
    err = !legal || (addr >= 32'(4 * WORDS)) || (legal && (off % size) != 0);
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < size; b++) mm[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (mm[idx] >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
        rd = val;
      end
    end
  endfunction

  // Monitor: abstract transaction tracker compared against the DUT every cycle
  bit          inflight = 1'b0;
  bit          chk_rst = 1'b0;
  int          age = 0;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_f3;
  logic [31:0] exp_rd = 32'd0;
  bit          exp_err = 1'b0;

  always @(negedge clk) begin
    if (chk_rst) begin
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk_rst = 1'b0;
    end
    if (rst) begin
      inflight = 1'b0;
      chk_rst  = 1'b1;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !inflight});
      chk("busy", {31'd0, busy}, {31'd0, inflight});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (inflight && age >= LATENCY)});
      if (inflight && age >= LATENCY) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
      if (!inflight) begin
        if (req_valid) begin
          inflight = 1'b1;
          age      = 0;
          p_we     = req_we;
          p_addr   = req_addr;
          p_wdata  = req_wdata;
          p_f3     = req_funct3;
        end
      end else if (age < LATENCY) begin
        age++;
        if (age == LATENCY) model_exec(p_we, p_addr, p_wdata, p_f3, exp_rd, exp_err);
      end else if (rsp_ready) begin
        inflight = 1'b0;
      end
    end
  end

  logic [31:0] got_rd;
  logic        got_err;
  int          lat;
  int          lowcnt;

  task automatic step();
    @(posedge clk);
    #1;
    if (!req_ready) lowcnt++;
  endtask

  task automatic scramble();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input int hold, input bit rnd);
    int n;
    bit hs;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) begin
      fail_now("txn_req_ready_timeout");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    rsp_ready  = rnd ? 1'($urandom) : (hold == 0);
    lowcnt = 0;
    lat    = 0;
    step();
    scramble();
    while (!rsp_valid && lat < 40) begin
      if (rnd) rsp_ready = 1'($urandom);
      step();
      scramble();
      lat++;
    end
    if (!rsp_valid) begin
      fail_now("txn_rsp_valid_timeout");
      req_valid = 1'b0;
      return;
    end
    got_rd  = rsp_rdata;
    got_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      step();
      scramble();
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, got_rd);
      chk("hold_rsp_err", {31'd0, rsp_err}, {31'd0, got_err});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    n = 0;
    do begin
      if (!rnd) rsp_ready = 1'b1;
      else if (!rsp_ready) rsp_ready = 1'($urandom);
      hs = rsp_ready;
      step();
      scramble();
      n++;
    end while (!hs && n < 40);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    if (!hs) fail_now("txn_handshake_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom, 3'b010, 0, 1'b0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0);
    chk("sw_latency", lat, 32'd2);
    chk("sw_ready_low", lowcnt, 32'd3);
    txn(1'b0, 32'h10, 32'd0, 3'b010, 0, 1'b0);
    chk("lw_rdata", got_rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, got_err}, 32'd0);
    chk("lw_latency", lat, 32'd2);
    chk("lw_ready_low", lowcnt, 32'd3);

    txn(1'b1, 32'h80, 32'h8001F0FF, 3'b010, 0, 1'b0);
    txn(1'b0, 32'h80, 32'd0, 3'b000, 0, 1'b0);
    chk("lb_0x80", got_rd, 32'hFFFFFFFF);
    txn(1'b0, 32'h80, 32'd0, 3'b100, 0, 1'b0);
    chk("lbu_0x80", got_rd, 32'h000000FF);
    txn(1'b0, 32'h82, 32'd0, 3'b001, 0, 1'b0);
    chk("lh_0x82", got_rd, 32'hFFFF8001);
    txn(1'b0, 32'h82, 32'd0, 3'b101, 0, 1'b0);
    chk("lhu_0x82", got_rd, 32'h00008001);

    txn(1'b1, 32'h20, 32'h0, 3'b010, 0, 1'b0);
    txn(1'b1, 32'h21, 32'hAA, 3'b000, 0, 1'b0);
    chk("sb_err", {31'd0, got_err}, 32'd0);
    txn(1'b0, 32'h20, 32'd0, 3'b010, 0, 1'b0);
    chk("sb_lane", got_rd, 32'h0000AA00);
    txn(1'b1, 32'h21, 32'h5555, 3'b001, 0, 1'b0);
    chk("sh_misalign_err", {31'd0, got_err}, 32'd1);
    chk("sh_misalign_rdata", got_rd, 32'd0);
    txn(1'b0, 32'h20, 32'd0, 3'b010, 0, 1'b0);
    chk("sh_no_write", got_rd, 32'h0000AA00);

    txn(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 0, 1'b0);
    txn(1'b0, 32'h30, 32'd0, 3'b010, 5, 1'b0);
    chk("bp_rdata", got_rd, 32'hCAFEF00D);
    chk("bp_ready_low", lowcnt, 32'd8);
    chk("bp_idle_after", {31'd0, req_ready}, 32'd1);

    txn(1'b1, 32'h40, 32'h11112222, 3'b010, 0, 1'b0);
    lowcnt = 0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'h12345678;
    req_funct3 = 3'b010;
    rsp_ready  = 1'b1;
    step();
    req_valid = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_drop_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
    txn(1'b0, 32'h40, 32'd0, 3'b010, 0, 1'b0);
    chk("rst_no_write", got_rd, 32'h11112222);
    txn(1'b0, 32'h1000, 32'd0, 3'b010, 0, 1'b0);
    chk("oor_err", {31'd0, got_err}, 32'd1);
    chk("oor_rdata", got_rd, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 3'b011, 0, 1'b0);
    chk("bad_load_f3", {31'd0, got_err}, 32'd1);
    txn(1'b1, 32'h40, 32'hFFFFFFFF, 3'b100, 0, 1'b0);
    chk("bad_store_f3", {31'd0, got_err}, 32'd1);
    txn(1'b1, 32'h42, 32'hFFFFFFFF, 3'b010, 0, 1'b0);
    chk("sw_misalign", {31'd0, got_err}, 32'd1);
    txn(1'b0, 32'h40, 32'd0, 3'b010, 0, 1'b0);
    chk("misalign_no_write", got_rd, 32'h11112222);

    for (int t = 0; t < 300; t++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_F000);
      if ($urandom_range(0, 3) == 0) begin
        txn(1'($urandom), a, $urandom, 3'($urandom), $urandom_range(0, 3), 1'b0);
      end else begin
        txn(1'($urandom), a, $urandom, 3'($urandom), 0, 1'b1);
      end
      n = $urandom_range(0, 2);
      repeat (n) step();
    end

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
